// File: rtl/uart_pkg.sv
// Shared UART definitions: drain FSM state encoding and default queue size.
// No ports; imported by byte_fifo and uart_tx_queue.
package uart_pkg;

  localparam int DEPTH_LOG_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    SETTLE = 2'd2
  } tx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with 2**DEPTH_LOG entries and wrap-around pointers.
// Ports: clk, reset, flush, push/wdata, pop/rdata, count, full, empty.
module byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG = DEPTH_LOG_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               push,
  input  logic [7:0]         wdata,
  input  logic               pop,
  output logic [7:0]         rdata,
  output logic [DEPTH_LOG:0] count,
  output logic               full,
  output logic               empty
);

  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] FULL_CNT = (DEPTH_LOG+1)'(DEPTH);

  logic [7:0]           mem [DEPTH];
  logic [DEPTH_LOG-1:0] wr_ptr;
  logic [DEPTH_LOG-1:0] rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // storage is deliberately left unreset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue feeding a UART transmitter with one-cycle load strobes.
// Ports: producer in_*, flush, transmitter tx_*, count, overflow.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG = DEPTH_LOG_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  output logic [7:0]         tx_data,
  output logic               tx_req,
  input  logic               tx_ready,
  output logic [DEPTH_LOG:0] count,
  output logic               overflow
);

  tx_state_t  state;
  tx_state_t  state_nx;
  logic       full;
  logic       empty;
  logic       push;
  logic       load;
  logic [7:0] head;

  assign in_ready = !full && !flush;
  assign push     = in_valid && in_ready;

  byte_fifo #(.DEPTH_LOG(DEPTH_LOG)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (push),
    .wdata (in_data),
    .pop   (load),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // SETTLE gives tx_ready time to fall after a load
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty && tx_ready) begin
          load     = 1'b1;
          state_nx = SEND;
        end
      end
      SEND:    state_nx = SETTLE;
      SETTLE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_req  <= 1'b0;
      tx_data <= 8'h00;
    end else begin
      tx_req <= load;
      if (load) tx_data <= head;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      overflow <= 1'b0;
    else if (flush)                 overflow <= 1'b0;
    else if (in_valid && !in_ready) overflow <= 1'b1;
  end

endmodule
